ldtu_data_lane_mux: RTL and testbench

Parametrised successor of the LiteDTU output-data multiplexer. Drives NLANES serialiser lanes of WIDTH bits, selecting among normal DTU data, calibration idle and per-lane ATU test data. Mode changes into or out of test go through a guard window of idle words so the downstream aligner never sees a mixed word. Sits between the DTU/ATU word builders and the serialiser lane inputs.

---
 rtl/ldtu_data_lane_mux.sv | 236 +++++++++++++++++++++++
 tb/tb_ldtu_data_lane_mux.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ldtu_data_lane_mux.sv
// ldtu_data_lane_mux
// Output-data multiplexer for NLANES serialiser lanes. Lane 0 carries DTU
// data in NORMAL, every lane can carry ATU test data in TEST, and any move
// into or out of TEST passes through a GUARD window of idle words. That way
// the downstream aligner never sees a word mixed from two modes.
// Optional build macro: LDTU_MUX_PRBS_EN adds a PRBS_SEL input and a PRBS15
// generator. This lets disabled test lanes carry pseudo-random words.
module ldtu_data_lane_mux #(
  parameter int               WIDTH       = 32,
  parameter int               NLANES      = 4,
  parameter int               GUARD_WORDS = 4,
  parameter logic [WIDTH-1:0] IDLE_NORMAL = 32'hEAAAAAAA,
  parameter logic [WIDTH-1:0] IDLE_TEST   = 32'h5A5A5A5A
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     CALIBRATION_BUSY,
  input  logic                     TEST_ENABLE,
  input  logic [NLANES-1:0]        LANE_EN,
`ifdef LDTU_MUX_PRBS_EN
  input  logic                     PRBS_SEL,
`endif
  input  logic [WIDTH-1:0]         DATA_DTU,
  input  logic [NLANES*WIDTH-1:0]  DATA_ATU,
  output logic [NLANES*WIDTH-1:0]  DATA_OUT,
  output logic [1:0]               MODE,
  output logic                     GUARD_ACTIVE,
  output logic [7:0]               SWITCH_COUNT
);

  typedef enum logic [1:0] {
    ST_NORMAL = 2'd0,
    ST_CALIB  = 2'd1,
    ST_TEST   = 2'd2,
    ST_GUARD  = 2'd3
  } state_t;

  localparam int              CNT_W        = (GUARD_WORDS > 1) ? $clog2(GUARD_WORDS) : 1;
  localparam logic [CNT_W-1:0] GUARD_RELOAD = CNT_W'(GUARD_WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO     = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  state_t                    state_r, state_nxt_s;
  state_t                    target_r, target_nxt_s;
  state_t                    req_s;
  logic [CNT_W-1:0]          guard_cnt_r, guard_cnt_nxt_s;
  logic                      switch_inc_s;
  logic [7:0]                switch_cnt_r;
  logic                      guard_active_r;
  logic [NLANES*WIDTH-1:0]   data_out_r;
  logic [NLANES*WIDTH-1:0]   lanes_nxt_s;
  logic [NLANES*WIDTH-1:0]   lanes_rst_s;
  logic [WIDTH-1:0]          disabled_word_s;

`ifdef LDTU_MUX_PRBS_EN
  localparam logic [14:0] PRBS_SEED = 15'h7FFF;

  logic [14:0]      prbs_r;
  logic [14:0]      prbs_base_s;
  logic [14:0]      prbs_nxt_s;
  logic [WIDTH-1:0] prbs_word_s;

  // PRBS15 (x^15 + x^14 + 1): WIDTH steps from a given state, first bit in the MSB.
  function automatic logic [15+WIDTH-1:0] prbs_advance(input logic [14:0] seed);
    logic [14:0]      s;
    logic [WIDTH-1:0] w;
    logic             b;
    s = seed;
    w = {WIDTH{1'b0}};
    for (int k = 0; k < WIDTH; k++) begin
      b = s[14] ^ s[13];
      s = {s[13:0], b};
      w[WIDTH-1-k] = b;
    end
    return {s, w};
  endfunction

  // Word for this cycle: continue the running sequence while in TEST, else restart from the seed.
  always_comb begin
    prbs_base_s = PRBS_SEED;
    if (state_r == ST_TEST) begin
      prbs_base_s = prbs_r;
    end else begin
      prbs_base_s = PRBS_SEED;
    end
    {prbs_nxt_s, prbs_word_s} = prbs_advance(prbs_base_s);
  end

  // Generator state: advances only while staying in TEST, parked at the seed otherwise.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      prbs_r <= PRBS_SEED;
    end else if (state_nxt_s == ST_TEST) begin
      prbs_r <= prbs_nxt_s;
    end else begin
      prbs_r <= PRBS_SEED;
    end
  end

  // Disabled test lanes carry PRBS when selected, idle otherwise.
  always_comb begin
    disabled_word_s = IDLE_TEST;
    if (PRBS_SEL) begin
      disabled_word_s = prbs_word_s;
    end else begin
      disabled_word_s = IDLE_TEST;
    end
  end
`else
  // Disabled test lanes always carry the test idle word.
  always_comb begin
    disabled_word_s = IDLE_TEST;
  end
`endif

  // Requested mode: TEST has priority over CALIB, and NORMAL is the fallback.
  always_comb begin
    req_s = ST_NORMAL;
    if (TEST_ENABLE) begin
      req_s = ST_TEST;
    end else if (CALIBRATION_BUSY) begin
      req_s = ST_CALIB;
    end else begin
      req_s = ST_NORMAL;
    end
  end

  // Next-state logic: direct NORMAL/CALIB swaps, guarded entry to and exit from TEST.
  always_comb begin
    state_nxt_s     = state_r;
    target_nxt_s    = target_r;
    guard_cnt_nxt_s = guard_cnt_r;
    switch_inc_s    = 1'b0;
    case (state_r)
      ST_NORMAL, ST_CALIB: begin
        if (req_s == state_r) begin
          state_nxt_s = state_r;
        end else if (req_s == ST_TEST) begin
          state_nxt_s     = ST_GUARD;
          target_nxt_s    = req_s;
          guard_cnt_nxt_s = GUARD_RELOAD;
        end else begin
          state_nxt_s  = req_s;
          switch_inc_s = 1'b1;
        end
      end
      ST_TEST: begin
        if (req_s != ST_TEST) begin
          state_nxt_s     = ST_GUARD;
          target_nxt_s    = req_s;
          guard_cnt_nxt_s = GUARD_RELOAD;
        end else begin
          state_nxt_s = ST_TEST;
        end
      end
      ST_GUARD: begin
        if (req_s == target_r) begin
          if (guard_cnt_r == CNT_ZERO) begin
            state_nxt_s  = target_r;
            switch_inc_s = 1'b1;
          end else begin
            guard_cnt_nxt_s = guard_cnt_r - CNT_ONE;
          end
        end else begin
          // A change of mind restarts the full window toward the new target.
          target_nxt_s    = req_s;
          guard_cnt_nxt_s = GUARD_RELOAD;
        end
      end
      default: begin
        state_nxt_s     = ST_NORMAL;
        target_nxt_s    = ST_NORMAL;
        guard_cnt_nxt_s = CNT_ZERO;
      end
    endcase
  end

  // Lane words for the state being entered at this edge.
  always_comb begin
    lanes_nxt_s = {NLANES{IDLE_TEST}};
    case (state_nxt_s)
      ST_NORMAL: lanes_nxt_s[0 +: WIDTH] = DATA_DTU;
      ST_CALIB:  lanes_nxt_s[0 +: WIDTH] = IDLE_NORMAL;
      ST_GUARD:  lanes_nxt_s[0 +: WIDTH] = IDLE_NORMAL;
      ST_TEST: begin
        for (int i = 0; i < NLANES; i++) begin
          if (LANE_EN[i]) begin
            lanes_nxt_s[i*WIDTH +: WIDTH] = DATA_ATU[i*WIDTH +: WIDTH];
          end else begin
            lanes_nxt_s[i*WIDTH +: WIDTH] = disabled_word_s;
          end
        end
      end
      default: lanes_nxt_s = {NLANES{IDLE_TEST}};
    endcase
  end

  // Lane words loaded at reset: lane 0 shows the idle word of the mode reset lands in.
  always_comb begin
    lanes_rst_s = {NLANES{IDLE_TEST}};
    if (TEST_ENABLE) begin
      lanes_rst_s[0 +: WIDTH] = IDLE_TEST;
    end else begin
      lanes_rst_s[0 +: WIDTH] = IDLE_NORMAL;
    end
  end

  // State, guard bookkeeping, the switch counter and the registered lane words.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_r        <= TEST_ENABLE ? ST_TEST : ST_NORMAL;
      target_r       <= TEST_ENABLE ? ST_TEST : ST_NORMAL;
      guard_cnt_r    <= CNT_ZERO;
      switch_cnt_r   <= 8'd0;
      guard_active_r <= 1'b0;
      data_out_r     <= lanes_rst_s;
    end else begin
      state_r        <= state_nxt_s;
      target_r       <= target_nxt_s;
      guard_cnt_r    <= guard_cnt_nxt_s;
      guard_active_r <= (state_nxt_s == ST_GUARD);
      data_out_r     <= lanes_nxt_s;
      if (switch_inc_s && (switch_cnt_r != 8'd255)) begin
        switch_cnt_r <= switch_cnt_r + 8'd1;
      end else begin
        switch_cnt_r <= switch_cnt_r;
      end
    end
  end

  assign DATA_OUT     = data_out_r;
  assign MODE         = state_r;
  assign GUARD_ACTIVE = guard_active_r;
  assign SWITCH_COUNT = switch_cnt_r;

endmodule

// File: tb/tb_ldtu_data_lane_mux.sv
// tb_ldtu_data_lane_mux
// Directed scenarios plus random stimulus, compared every cycle against a
// mode-level reference model. Define LDTU_MUX_PRBS_EN to cover the PRBS lanes.
module tb_ldtu_data_lane_mux;

  localparam int          W  = 32;
  localparam int          NL = 4;
  localparam int          GW = 4;
  localparam logic [W-1:0] IN = 32'hEAAAAAAA;
  localparam logic [W-1:0] IT = 32'h5A5A5A5A;

  logic            CLK = 1'b0;
  logic            RST = 1'b0;
  logic            CALIBRATION_BUSY = 1'b0;
  logic            TEST_ENABLE = 1'b0;
  logic [NL-1:0]   LANE_EN = '0;
  logic [W-1:0]    DATA_DTU = '0;
  logic [NL*W-1:0] DATA_ATU = '0;
  logic [NL*W-1:0] DATA_OUT;
  logic [1:0]      MODE;
  logic            GUARD_ACTIVE;
  logic [7:0]      SWITCH_COUNT;
`ifdef LDTU_MUX_PRBS_EN
  logic            PRBS_SEL = 1'b0;
  logic [14:0]     m_lfsr = 15'h7FFF;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model state: mode (0 NORMAL,1 CALIB,2 TEST,3 GUARD), guard target,
  // matching edges seen since the window (re)started, and completed switches.
  int              m_mode = 0;
  int              m_target = 0;
  int              m_seen = 0;
  int              m_sw = 0;
  logic [NL*W-1:0] exp_data = '0;

  ldtu_data_lane_mux #(.WIDTH(W), .NLANES(NL), .GUARD_WORDS(GW)) dut (
    .CLK(CLK), .RST(RST), .CALIBRATION_BUSY(CALIBRATION_BUSY),
    .TEST_ENABLE(TEST_ENABLE), .LANE_EN(LANE_EN),
`ifdef LDTU_MUX_PRBS_EN
    .PRBS_SEL(PRBS_SEL),
`endif
    .DATA_DTU(DATA_DTU), .DATA_ATU(DATA_ATU), .DATA_OUT(DATA_OUT),
    .MODE(MODE), .GUARD_ACTIVE(GUARD_ACTIVE), .SWITCH_COUNT(SWITCH_COUNT));

  always #5 CLK = ~CLK;

  task automatic chk_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

`ifdef LDTU_MUX_PRBS_EN
  // Next W bits of the PRBS15 bit stream, earliest bit ends up in the MSB.
  task automatic prbs_word(output logic [W-1:0] word);
    logic b;
    word = '0;
    for (int k = 0; k < W; k++) begin
      b = m_lfsr[14] ^ m_lfsr[13];
      m_lfsr = {m_lfsr[13:0], b};
      word = {word[W-2:0], b};
    end
  endtask
`endif

  // Apply one clock edge to the model using the inputs present at that edge.
  task automatic model_edge();
    int         req;
    int         prev;
    logic [W-1:0] dis;
    req  = TEST_ENABLE ? 2 : (CALIBRATION_BUSY ? 1 : 0);
    prev = m_mode;
    if (!RST) begin
      m_mode = TEST_ENABLE ? 2 : 0;
      m_target = m_mode;
      m_seen = 0;
      m_sw = 0;
      exp_data = {NL{IT}};
      if (!TEST_ENABLE) exp_data[W-1:0] = IN;
`ifdef LDTU_MUX_PRBS_EN
      m_lfsr = 15'h7FFF;
`endif
      return;
    end
    if (m_mode == 3) begin
      if (req == m_target) begin
        m_seen++;
        if (m_seen == GW) begin
          m_mode = m_target;
          m_sw = (m_sw < 255) ? m_sw + 1 : 255;
        end
      end else begin
        m_target = req;
        m_seen = 0;
      end
    end else if (req != m_mode) begin
      if (req == 2 || m_mode == 2) begin
        m_mode = 3;
        m_target = req;
        m_seen = 0;
      end else begin
        m_mode = req;
        m_sw = (m_sw < 255) ? m_sw + 1 : 255;
      end
    end
    dis = IT;
`ifdef LDTU_MUX_PRBS_EN
    if (m_mode == 2) begin
      logic [W-1:0] pw;
      if (prev != 2) m_lfsr = 15'h7FFF;
      prbs_word(pw);
      if (PRBS_SEL) dis = pw;
    end
`endif
    exp_data = {NL{IT}};
    case (m_mode)
      0: exp_data[W-1:0] = DATA_DTU;
      1, 3: exp_data[W-1:0] = IN;
      default: begin
        for (int i = 0; i < NL; i++)
          exp_data[i*W +: W] = LANE_EN[i] ? DATA_ATU[i*W +: W] : dis;
      end
    endcase
    if (prev < 0) $display("unreachable");
  endtask

  // One clock: edge, model update, then sample outputs 1 time unit later.
  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
    chk_eq("data_out", DATA_OUT, exp_data);
    chk_eq("mode", MODE, m_mode[1:0]);
    chk_eq("guard_active", GUARD_ACTIVE, (m_mode == 3));
    chk_eq("switch_count", SWITCH_COUNT, m_sw[7:0]);
  endtask

  initial begin
    // Reset into NORMAL, then the first DTU word appears one edge later.
    RST = 1'b0; TEST_ENABLE = 1'b0; CALIBRATION_BUSY = 1'b0;
    step(); step();
    chk_eq("rst_lane0", DATA_OUT[31:0], 32'hEAAAAAAA);
    chk_eq("rst_lanes", DATA_OUT[127:32], {3{32'h5A5A5A5A}});
    chk_eq("rst_mode", MODE, 2'd0);
    chk_eq("rst_sw", SWITCH_COUNT, 8'd0);
    RST = 1'b1; DATA_DTU = 32'h12345678;
    step();
    chk_eq("dtu_lat", DATA_OUT[31:0], 32'h12345678);

    // NORMAL -> TEST through a four-word guard window.
    LANE_EN = 4'b1011;
    DATA_ATU = {32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1, 32'hA0A0A0A0};
    TEST_ENABLE = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_eq("guard_mode", MODE, 2'd3);
      chk_eq("guard_lane0", DATA_OUT[31:0], 32'hEAAAAAAA);
    end
    step();
    chk_eq("test_mode", MODE, 2'd2);
    chk_eq("test_lanes", DATA_OUT,
           {32'hA3A3A3A3, 32'h5A5A5A5A, 32'hA1A1A1A1, 32'hA0A0A0A0});
    chk_eq("test_sw", SWITCH_COUNT, 8'd1);

    // Back to NORMAL, then a three-cycle calibration pulse with no guard.
    TEST_ENABLE = 1'b0;
    repeat (5) step();
    CALIBRATION_BUSY = 1'b1;
    repeat (3) begin
      step();
      chk_eq("calib_lane0", DATA_OUT[31:0], 32'hEAAAAAAA);
      chk_eq("calib_noguard", GUARD_ACTIVE, 1'b0);
    end
    CALIBRATION_BUSY = 1'b0; DATA_DTU = 32'hCAFEF00D;
    step();
    chk_eq("calib_sw", SWITCH_COUNT, 8'd4);

    // Abort a NORMAL->TEST guard after two cycles: window restarts toward NORMAL.
    TEST_ENABLE = 1'b1;
    repeat (2) step();
    TEST_ENABLE = 1'b0;
    repeat (4) begin
      step();
      chk_eq("abort_guard", MODE, 2'd3);
    end
    step();
    chk_eq("abort_lane0", DATA_OUT[31:0], 32'hCAFEF00D);
    chk_eq("abort_sw", SWITCH_COUNT, 8'd5);

    // Reset in the middle of a guard with TEST_ENABLE high lands directly in TEST.
    TEST_ENABLE = 1'b1;
    repeat (2) step();
    RST = 1'b0;
    step();
    chk_eq("rstg_mode", MODE, 2'd2);
    chk_eq("rstg_ga", GUARD_ACTIVE, 1'b0);
    chk_eq("rstg_lane0", DATA_OUT[31:0], 32'h5A5A5A5A);
    RST = 1'b1; TEST_ENABLE = 1'b0;
    repeat (5) step();

    // 300 NORMAL/CALIB swaps saturate the switch counter.
    for (int i = 0; i < 300; i++) begin
      CALIBRATION_BUSY = ~CALIBRATION_BUSY;
      step();
    end
    chk_eq("sat_sw", SWITCH_COUNT, 8'd255);
    CALIBRATION_BUSY = 1'b0;

`ifdef LDTU_MUX_PRBS_EN
    // PRBS on all lanes from reset into TEST, then leave and re-enter TEST.
    RST = 1'b0; TEST_ENABLE = 1'b1; LANE_EN = '0; PRBS_SEL = 1'b1;
    step();
    RST = 1'b1;
    repeat (6) step();
    TEST_ENABLE = 1'b0;
    repeat (6) step();
    TEST_ENABLE = 1'b1;
    repeat (10) step();
`endif

    // Random phase: slowly changing mode requests, random data and occasional reset.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(15) == 0) TEST_ENABLE = ~TEST_ENABLE;
      if ($urandom_range(5) == 0) CALIBRATION_BUSY = ~CALIBRATION_BUSY;
      if ($urandom_range(7) == 0) LANE_EN = NL'($urandom);
`ifdef LDTU_MUX_PRBS_EN
      if ($urandom_range(9) == 0) PRBS_SEL = ~PRBS_SEL;
`endif
      RST = ($urandom_range(199) == 0) ? 1'b0 : 1'b1;
      DATA_DTU = $urandom;
      DATA_ATU = {$urandom, $urandom, $urandom, $urandom};
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
